// File: rtl/dl_rom_packer.sv
// rtl/dl_rom_packer.sv - packs the byte-wide ROM download stream of one address region into DLROM words
module dl_rom_packer #(
  parameter int          AW   = 8,
  parameter int          DW   = 8,
  parameter logic [23:0] BASE = 24'h0,
  parameter logic [7:0]  FILL = 8'hFF
) (
  input  logic          CL,
  input  logic          RST_N,
  input  logic          DL_EN,
  input  logic          DL_WR,
  input  logic [23:0]   DL_AD,
  input  logic [7:0]    DL_DT,
  output logic [AW-1:0] AD1,
  output logic [DW-1:0] DI1,
  output logic          WE1,
  output logic          DONE
);

  localparam int          NB        = DW / 8;
  localparam logic [24:0] REGION    = 25'(NB) << AW;
  localparam logic [DW-1:0] FILL_WORD = {NB{FILL}};

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, FIN} state_t;

  state_t          state_q, state_d;
  logic            dl_en_q;
  logic [DW-1:0]   buf_q, buf_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   word_q, word_d;
  logic [AW-1:0]   ad1_q, ad1_d;
  logic [DW-1:0]   di1_q, di1_d;
  logic            we1_q, we1_d;
  logic            done_q, done_d;

  logic [23:0]     off;
  logic [23:0]     lane;
  logic [AW-1:0]   word;
  logic            hit;
  logic            rise;
  logic            last_lane;
  logic            new_word;
  logic [DW-1:0]   merged;

  assign off       = DL_AD - BASE;
  assign lane      = off % 24'(NB);
  assign word      = AW'(off / 24'(NB));
  assign hit       = DL_WR && (DL_AD >= BASE) && ({1'b0, off} < REGION);
  assign rise      = DL_EN && !dl_en_q;
  assign last_lane = (lane == 24'(NB - 1));
  assign new_word  = pend_q && (word != word_q);

  always_comb begin
    merged = new_word ? FILL_WORD : buf_q;
    for (int k = 0; k < NB; k++) begin
      if (lane == 24'(k)) merged[8*k +: 8] = DL_DT;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    word_d  = word_q;
    ad1_d   = ad1_q;
    di1_d   = di1_q;
    we1_d   = 1'b0;
    done_d  = done_q;
    case (state_q)
      IDLE, FIN: begin
        if (rise) begin
          state_d = ACTIVE;
          done_d  = 1'b0;
          buf_d   = FILL_WORD;
          pend_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (hit) begin
          if (new_word) begin
            // Old partial word takes this cycle's write; the new byte stays pending even in the top lane.
            we1_d  = 1'b1;
            ad1_d  = word_q;
            di1_d  = buf_q;
            buf_d  = merged;
            pend_d = 1'b1;
            word_d = word;
          end else if (last_lane) begin
            we1_d  = 1'b1;
            ad1_d  = word;
            di1_d  = merged;
            buf_d  = FILL_WORD;
            pend_d = 1'b0;
          end else begin
            buf_d  = merged;
            pend_d = 1'b1;
            word_d = word;
          end
        end
        if (!DL_EN) state_d = FLUSH;
      end
      FLUSH: begin
        if (pend_q) begin
          we1_d  = 1'b1;
          ad1_d  = word_q;
          di1_d  = buf_q;
          buf_d  = FILL_WORD;
          pend_d = 1'b0;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      // Starting high means a level already high out of reset is not taken as a rise.
      dl_en_q <= 1'b1;
      buf_q   <= FILL_WORD;
      pend_q  <= 1'b0;
      word_q  <= '0;
      ad1_q   <= '0;
      di1_q   <= '0;
      we1_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_en_q <= DL_EN;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      ad1_q   <= ad1_d;
      di1_q   <= di1_d;
      we1_q   <= we1_d;
      done_q  <= done_d;
    end
  end

  assign AD1  = ad1_q;
  assign DI1  = di1_q;
  assign WE1  = we1_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_dl_rom_packer.sv
// tb/tb_dl_rom_packer.sv - scoreboard bench for dl_rom_packer with DW=16 AW=4 BASE=0x100
module tb_dl_rom_packer;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          CL = 1'b0;
  logic          RST_N;
  logic          DL_EN;
  logic          DL_WR;
  logic [23:0]   DL_AD;
  logic [7:0]    DL_DT;
  logic [AW-1:0] AD1;
  logic [DW-1:0] DI1;
  logic          WE1;
  logic          DONE;

  dl_rom_packer #(.AW(AW), .DW(DW), .BASE(24'h100), .FILL(8'hFF)) dut (
    .CL(CL), .RST_N(RST_N), .DL_EN(DL_EN), .DL_WR(DL_WR), .DL_AD(DL_AD),
    .DL_DT(DL_DT), .AD1(AD1), .DI1(DI1), .WE1(WE1), .DONE(DONE)
  );

  always #5 CL = ~CL;

  typedef struct packed {
    logic [AW-1:0] ad;
    logic [DW-1:0] di;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_pushed = 0;
  int  n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] ad, input logic [DW-1:0] di);
    exp_q.push_back('{ad: ad, di: di});
    n_pushed++;
  endtask

  task automatic send(input logic [23:0] ad, input logic [7:0] dt);
    DL_WR = 1'b1;
    DL_AD = ad;
    DL_DT = dt;
    tick();
    DL_WR = 1'b0;
  endtask

  task automatic start_dl();
    DL_EN = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 8 && !DONE; i++) tick();
    check(name, {31'd0, DONE}, 32'd1);
  endtask

  task automatic end_dl(input string name);
    DL_EN = 1'b0;
    tick();
    wait_done(name);
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge CL);
      if (RST_N && WE1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_we1", {28'd0, AD1}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_ad1", {28'd0, AD1}, {28'd0, e.ad});
          check("wr_di1", {16'd0, DI1}, {16'd0, e.di});
        end
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    DL_EN = 1'b0;
    DL_WR = 1'b0;
    DL_AD = '0;
    DL_DT = '0;
    tick();
    tick();
    check("rst_we1", {31'd0, WE1}, 32'd0);
    check("rst_ad1", {28'd0, AD1}, 32'd0);
    check("rst_di1", {16'd0, DI1}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    RST_N = 1'b1;
    tick();

    // T1: single full word
    start_dl();
    send(24'h100, 8'hAA);
    push(4'd0, 16'hBBAA);
    send(24'h101, 8'hBB);
    end_dl("t1_done");

    // T2: full region streamed with DL_WR held high
    start_dl();
    check("t2_done_cleared", {31'd0, DONE}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1)
        push(AW'(i / 2), {8'(i * 7 + 3), 8'((i - 1) * 7 + 3)});
      send(24'h100 + 24'(i), 8'(i * 7 + 3));
    end
    end_dl("t2_done");

    // T3: out-of-region bytes only
    start_dl();
    send(24'h0FF, 8'h11);
    send(24'h120, 8'h22);
    end_dl("t3_done");

    // T4: odd-length load flushes a FILL-padded word
    start_dl();
    push(4'd0, 16'h4140);
    push(4'd1, 16'h4342);
    push(4'd2, 16'hFF44);
    for (int i = 0; i < 5; i++) send(24'h100 + 24'(i), 8'(8'h40 + i));
    DL_EN = 1'b0;
    tick();
    tick();
    check("t4_flush_we1", {31'd0, WE1}, 32'd1);
    check("t4_done_low", {31'd0, DONE}, 32'd0);
    tick();
    check("t4_done_high", {31'd0, DONE}, 32'd1);
    check("t4_we1_low", {31'd0, WE1}, 32'd0);

    // T5: last byte arrives in the same cycle DL_EN falls
    start_dl();
    send(24'h100, 8'h5A);
    push(4'd0, 16'hA55A);
    DL_EN = 1'b0;
    send(24'h101, 8'hA5);
    wait_done("t5_done");

    // T6: reset mid-word discards the partial word
    start_dl();
    send(24'h102, 8'h77);
    RST_N = 1'b0;
    #1;
    check("t6_we1", {31'd0, WE1}, 32'd0);
    check("t6_ad1", {28'd0, AD1}, 32'd0);
    check("t6_di1", {16'd0, DI1}, 32'd0);
    check("t6_done", {31'd0, DONE}, 32'd0);
    DL_EN = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    tick();

    // Restart after reset, with a word change while a partial word is pending
    start_dl();
    push(4'd0, 16'hFF11);
    push(4'd7, 16'h0201);
    push(4'd2, 16'hFF22);
    send(24'h100, 8'h11);
    send(24'h10E, 8'h01);
    send(24'h10F, 8'h02);
    send(24'h104, 8'h22);
    end_dl("t6_restart_done");

    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(n_writes), 32'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
